// File: rtl/interconnect_pkg.sv
// Shared constants for the QoS interconnect control FSM.
// Holds the state encoding and the FIFO flag bit indices.
package interconnect_pkg;

    localparam logic [2:0] ST_RESET  = 3'd0;
    localparam logic [2:0] ST_INIT   = 3'd1;
    localparam logic [2:0] ST_IDLE   = 3'd2;
    localparam logic [2:0] ST_ACTIVE = 3'd3;
    localparam logic [2:0] ST_ERROR  = 3'd4;

    typedef enum logic [2:0] {
        S_RESET  = ST_RESET,
        S_INIT   = ST_INIT,
        S_IDLE   = ST_IDLE,
        S_ACTIVE = ST_ACTIVE,
        S_ERROR  = ST_ERROR
    } state_e;

    localparam int FIFO_N  = 5;
    localparam int FIF_MAIN = 0;
    localparam int FIF_VC0  = 1;
    localparam int FIF_VC1  = 2;
    localparam int FIF_D0   = 3;
    localparam int FIF_D1   = 4;

    localparam logic [FIFO_N-1:0] ALL_EMPTY = '1;

endpackage

// File: rtl/interconnect_fsm_if.sv
// Control bundle between the interconnect datapath and interconnect_fsm.
// slave: FSM side (thresholds in, flags in; thresholds/status out).
interface interconnect_fsm_if #(
    parameter int LEN4  = 4,
    parameter int LEN16 = 16
);
    logic             init;
    logic [LEN4-1:0]  UmbralMF_HIGH_in;
    logic [LEN4-1:0]  UmbralMF_LOW_in;
    logic [LEN16-1:0] UmbralVC_HIGH_in;
    logic [LEN16-1:0] UmbralVC_LOW_in;
    logic [LEN4-1:0]  UmbralD_HIGH_in;
    logic [LEN4-1:0]  UmbralD_LOW_in;
    logic [4:0]       fifo_empty;
    logic [4:0]       fifo_error;

    logic [LEN4-1:0]  UmbralMF_HIGH;
    logic [LEN4-1:0]  UmbralMF_LOW;
    logic [LEN16-1:0] UmbralVC_HIGH;
    logic [LEN16-1:0] UmbralVC_LOW;
    logic [LEN4-1:0]  UmbralD_HIGH;
    logic [LEN4-1:0]  UmbralD_LOW;
    logic [2:0]       state;
    logic             flow_en;
    logic             idle_out;
    logic             active_out;
    logic             error_out;
    logic             cfg_bad;
    logic [4:0]       error_src;

    modport master (
        output init,
        output UmbralMF_HIGH_in, UmbralMF_LOW_in,
        output UmbralVC_HIGH_in, UmbralVC_LOW_in,
        output UmbralD_HIGH_in, UmbralD_LOW_in,
        output fifo_empty, fifo_error,
        input  UmbralMF_HIGH, UmbralMF_LOW,
        input  UmbralVC_HIGH, UmbralVC_LOW,
        input  UmbralD_HIGH, UmbralD_LOW,
        input  state, flow_en, idle_out,
        input  active_out, error_out,
        input  cfg_bad, error_src
    );

    modport slave (
        input  init,
        input  UmbralMF_HIGH_in, UmbralMF_LOW_in,
        input  UmbralVC_HIGH_in, UmbralVC_LOW_in,
        input  UmbralD_HIGH_in, UmbralD_LOW_in,
        input  fifo_empty, fifo_error,
        output UmbralMF_HIGH, UmbralMF_LOW,
        output UmbralVC_HIGH, UmbralVC_LOW,
        output UmbralD_HIGH, UmbralD_LOW,
        output state, flow_en, idle_out,
        output active_out, error_out,
        output cfg_bad, error_src
    );

endinterface

// File: rtl/interconnect_fsm.sv
// Control FSM for the QoS interconnect: threshold load/hold, Main
// write gating, idle tracking over five FIFOs, sticky error capture.
// Ports: clk, reset_L (sync, active-low), bus (interconnect_fsm_if.slave).
module interconnect_fsm
    import interconnect_pkg::*;
#(
    parameter int LEN4     = 4,
    parameter int LEN16    = 16,
    parameter int IDLE_CNT = 4
) (
    input logic               clk,
    input logic               reset_L,
    interconnect_fsm_if.slave bus
);

    localparam int CW = $clog2(IDLE_CNT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(IDLE_CNT - 1);

    state_e state_q, state_d;

    logic [LEN4-1:0]  mf_hi_q, mf_hi_d;
    logic [LEN4-1:0]  mf_lo_q, mf_lo_d;
    logic [LEN16-1:0] vc_hi_q, vc_hi_d;
    logic [LEN16-1:0] vc_lo_q, vc_lo_d;
    logic [LEN4-1:0]  d_hi_q, d_hi_d;
    logic [LEN4-1:0]  d_lo_q, d_lo_d;

    logic          cfg_bad_q, cfg_bad_d;
    logic          load_q, load_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    src_q, src_d;

    logic all_empty;
    logic any_err;

    assign all_empty = (bus.fifo_empty == ALL_EMPTY);
    assign any_err   = |bus.fifo_error;

    always_comb begin
        state_d = state_q;
        mf_hi_d = mf_hi_q;
        mf_lo_d = mf_lo_q;
        vc_hi_d = vc_hi_q;
        vc_lo_d = vc_lo_q;
        d_hi_d  = d_hi_q;
        d_lo_d  = d_lo_q;
        load_d  = 1'b0;
        cnt_d   = '0;
        src_d   = src_q;
        // Checked against the registered thresholds, so it trails a load.
        cfg_bad_d = (mf_lo_q >= mf_hi_q)
                  | (vc_lo_q >= vc_hi_q)
                  | (d_lo_q >= d_hi_q);

        unique case (state_q)
            S_RESET: begin
                state_d = S_INIT;
            end
            S_INIT: begin
                // load_q blocks exit until cfg_bad_q reflects the last load.
                load_d = bus.init;
                if (bus.init) begin
                    mf_hi_d = bus.UmbralMF_HIGH_in;
                    mf_lo_d = bus.UmbralMF_LOW_in;
                    vc_hi_d = bus.UmbralVC_HIGH_in;
                    vc_lo_d = bus.UmbralVC_LOW_in;
                    d_hi_d  = bus.UmbralD_HIGH_in;
                    d_lo_d  = bus.UmbralD_LOW_in;
                end else if (!load_q && !cfg_bad_q) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (any_err) begin
                    state_d = S_ERROR;
                    src_d   = bus.fifo_error;
                end else if (bus.init) begin
                    state_d = S_INIT;
                    load_d  = 1'b1;
                end else if (!all_empty) begin
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (any_err) begin
                    state_d = S_ERROR;
                    src_d   = bus.fifo_error;
                end else if (all_empty) begin
                    if (cnt_q >= CNT_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
            default: begin
                state_d = S_RESET;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state_q   <= S_RESET;
            mf_hi_q   <= '0;
            mf_lo_q   <= '0;
            vc_hi_q   <= '0;
            vc_lo_q   <= '0;
            d_hi_q    <= '0;
            d_lo_q    <= '0;
            cfg_bad_q <= 1'b0;
            load_q    <= 1'b0;
            cnt_q     <= '0;
            src_q     <= '0;
        end else begin
            state_q   <= state_d;
            mf_hi_q   <= mf_hi_d;
            mf_lo_q   <= mf_lo_d;
            vc_hi_q   <= vc_hi_d;
            vc_lo_q   <= vc_lo_d;
            d_hi_q    <= d_hi_d;
            d_lo_q    <= d_lo_d;
            cfg_bad_q <= cfg_bad_d;
            load_q    <= load_d;
            cnt_q     <= cnt_d;
            src_q     <= src_d;
        end
    end

    assign bus.UmbralMF_HIGH = mf_hi_q;
    assign bus.UmbralMF_LOW  = mf_lo_q;
    assign bus.UmbralVC_HIGH = vc_hi_q;
    assign bus.UmbralVC_LOW  = vc_lo_q;
    assign bus.UmbralD_HIGH  = d_hi_q;
    assign bus.UmbralD_LOW   = d_lo_q;

    assign bus.state      = state_q;
    assign bus.idle_out   = (state_q == S_IDLE);
    assign bus.active_out = (state_q == S_ACTIVE);
    assign bus.error_out  = (state_q == S_ERROR);
    assign bus.flow_en    = (state_q == S_IDLE)
                          | (state_q == S_ACTIVE);
    assign bus.cfg_bad    = (state_q == S_INIT) & cfg_bad_q;
    assign bus.error_src  = src_q;

endmodule

// File: tb/tb_interconnect_fsm.sv
// Directed self-checking bench for interconnect_fsm.
// Expected values are hand-computed constants.
module tb_interconnect_fsm;

    logic clk;
    logic reset_L;
    int   total;
    int   bad;

    interconnect_fsm_if #(.LEN4(4), .LEN16(16)) bus_if ();

    interconnect_fsm #(
        .LEN4(4), .LEN16(16), .IDLE_CNT(4)
    ) dut (
        .clk    (clk),
        .reset_L(reset_L),
        .bus    (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [3:0] mh, input logic [3:0] ml,
                       input logic [15:0] vh, input logic [15:0] vl,
                       input logic [3:0] dh, input logic [3:0] dl);
        bus_if.UmbralMF_HIGH_in = mh;
        bus_if.UmbralMF_LOW_in  = ml;
        bus_if.UmbralVC_HIGH_in = vh;
        bus_if.UmbralVC_LOW_in  = vl;
        bus_if.UmbralD_HIGH_in  = dh;
        bus_if.UmbralD_LOW_in   = dl;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset_L = 1'b0;
        bus_if.init = 1'b0;
        bus_if.fifo_empty = 5'h1f;
        bus_if.fifo_error = 5'h00;
        cfg(4'd0, 4'd0, 16'd0, 16'd0, 4'd0, 4'd0);

        // reset
        step();
        chk("rst_state_e1", bus_if.state, 3'd0);
        step();
        step();
        chk("rst_state", bus_if.state, 3'd0);
        chk("rst_flow", bus_if.flow_en, 1'b0);
        chk("rst_idle", bus_if.idle_out, 1'b0);
        chk("rst_act", bus_if.active_out, 1'b0);
        chk("rst_err", bus_if.error_out, 1'b0);
        chk("rst_cfgbad", bus_if.cfg_bad, 1'b0);
        chk("rst_src", bus_if.error_src, 5'h00);
        chk("rst_mfh", bus_if.UmbralMF_HIGH, 4'd0);
        chk("rst_vch", bus_if.UmbralVC_HIGH, 16'd0);

        reset_L = 1'b1;
        step();
        chk("init_state", bus_if.state, 3'd1);
        chk("init_flow", bus_if.flow_en, 1'b0);
        chk("init_cfgbad0", bus_if.cfg_bad, 1'b1);

        // good load
        cfg(4'd12, 4'd3, 16'd40, 16'd5, 4'd10, 4'd2);
        bus_if.init = 1'b1;
        step();
        chk("ld_mfh", bus_if.UmbralMF_HIGH, 4'd12);
        chk("ld_mfl", bus_if.UmbralMF_LOW, 4'd3);
        chk("ld_vch", bus_if.UmbralVC_HIGH, 16'd40);
        chk("ld_vcl", bus_if.UmbralVC_LOW, 16'd5);
        chk("ld_dh", bus_if.UmbralD_HIGH, 4'd10);
        chk("ld_dl", bus_if.UmbralD_LOW, 4'd2);
        bus_if.init = 1'b0;
        step();
        chk("ld_wait_state", bus_if.state, 3'd1);
        chk("ld_cfgbad", bus_if.cfg_bad, 1'b0);
        step();
        chk("ld_idle_state", bus_if.state, 3'd2);
        chk("ld_flow", bus_if.flow_en, 1'b1);
        chk("ld_idle_out", bus_if.idle_out, 1'b1);

        // bad load from IDLE
        cfg(4'd4, 4'd9, 16'd40, 16'd5, 4'd10, 4'd2);
        bus_if.init = 1'b1;
        step();
        chk("re_state", bus_if.state, 3'd1);
        chk("re_hold_mfh", bus_if.UmbralMF_HIGH, 4'd12);
        step();
        chk("bad_mfh", bus_if.UmbralMF_HIGH, 4'd4);
        chk("bad_mfl", bus_if.UmbralMF_LOW, 4'd9);
        bus_if.init = 1'b0;
        step();
        chk("bad_cfgbad", bus_if.cfg_bad, 1'b1);
        step();
        step();
        chk("bad_stay", bus_if.state, 3'd1);
        chk("bad_cfgbad2", bus_if.cfg_bad, 1'b1);
        cfg(4'd12, 4'd3, 16'd40, 16'd5, 4'd10, 4'd2);
        bus_if.init = 1'b1;
        step();
        bus_if.init = 1'b0;
        step();
        chk("fix_cfgbad", bus_if.cfg_bad, 1'b0);
        step();
        chk("fix_idle", bus_if.state, 3'd2);

        // idle counting
        bus_if.fifo_empty = 5'b11110;
        step();
        chk("act_state", bus_if.state, 3'd3);
        chk("act_out", bus_if.active_out, 1'b1);
        bus_if.fifo_empty = 5'h1f;
        for (int i = 1; i <= 3; i++) begin
            step();
            chk($sformatf("cnt_%0d", i), bus_if.state, 3'd3);
        end
        step();
        chk("cnt_4_idle", bus_if.state, 3'd2);

        // restart of count
        bus_if.fifo_empty = 5'b10111;
        step();
        chk("rs_act", bus_if.state, 3'd3);
        bus_if.fifo_empty = 5'h1f;
        repeat (3) step();
        chk("rs_3", bus_if.state, 3'd3);
        bus_if.fifo_empty = 5'b01111;
        step();
        chk("rs_break", bus_if.state, 3'd3);
        bus_if.fifo_empty = 5'h1f;
        repeat (3) step();
        chk("rs_again3", bus_if.state, 3'd3);
        step();
        chk("rs_idle", bus_if.state, 3'd2);

        // init ignored in ACTIVE, then error
        bus_if.fifo_empty = 5'b11110;
        step();
        bus_if.init = 1'b1;
        step();
        chk("act_init_ign", bus_if.state, 3'd3);
        bus_if.fifo_empty = 5'h1f;
        bus_if.fifo_error = 5'b01000;
        step();
        chk("err_state", bus_if.state, 3'd4);
        chk("err_src", bus_if.error_src, 5'b01000);
        chk("err_flow", bus_if.flow_en, 1'b0);
        chk("err_out", bus_if.error_out, 1'b1);
        bus_if.fifo_error = 5'b00001;
        step();
        bus_if.init = 1'b0;
        bus_if.fifo_error = 5'h00;
        step();
        chk("err_sticky", bus_if.state, 3'd4);
        chk("err_src_keep", bus_if.error_src, 5'b01000);

        // reset from ERROR
        reset_L = 1'b0;
        step();
        chk("re_rst_state", bus_if.state, 3'd0);
        chk("re_rst_src", bus_if.error_src, 5'h00);
        chk("re_rst_mfh", bus_if.UmbralMF_HIGH, 4'd0);
        chk("re_rst_vcl", bus_if.UmbralVC_LOW, 16'd0);
        chk("re_rst_flow", bus_if.flow_en, 1'b0);
        reset_L = 1'b1;
        step();
        chk("re_init", bus_if.state, 3'd1);

        // error beats non-empty and init in IDLE
        bus_if.init = 1'b1;
        step();
        bus_if.init = 1'b0;
        step();
        step();
        chk("pr_idle", bus_if.state, 3'd2);
        bus_if.init = 1'b1;
        bus_if.fifo_empty = 5'b11110;
        bus_if.fifo_error = 5'b00010;
        step();
        chk("pr_err", bus_if.state, 3'd4);
        chk("pr_src", bus_if.error_src, 5'b00010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/interconnect_fsm.md
# interconnect_fsm

Control state machine for the QoS interconnect. It loads and holds the FIFO threshold registers (Umbral*), gates traffic into the Main FIFO, tracks activity and idle periods across the five FIFOs (Main, VC0, VC1, D0, D1), and latches any FIFO error. It sits beside the interconnect datapath: its threshold outputs drive the FIFOs' Umbral inputs, its `flow_en` gates `Main_wr`, and it reads the FIFOs' empty and error flags.

## Interface
- `LEN4`, default 4: width of the Main, D0 and D1 thresholds.
- `LEN16`, default 16: width of the VC0 and VC1 thresholds.
- `IDLE_CNT`, default 4: number of consecutive all-empty cycles required to leave ACTIVE.

Ports:
- `clk`  in  1  — the single clock; all logic is on the rising edge.
- `reset_L`  in  1  — reset, synchronous and active-low.
- `init`  in  1  — request to (re)load the thresholds.
- `UmbralMF_HIGH_in` / `UmbralMF_LOW_in`  in  LEN4 each  — Main thresholds to load.
- `UmbralVC_HIGH_in` / `UmbralVC_LOW_in`  in  LEN16 each  — thresholds to load, shared by VC0 and VC1.
- `UmbralD_HIGH_in` / `UmbralD_LOW_in`  in  LEN4 each  — thresholds to load, shared by D0 and D1.
- `fifo_empty`  in  5  — empty flags, bit order {D1, D0, VC1, VC0, Main}.
- `fifo_error`  in  5  — error flags, same bit order.
- `UmbralMF_HIGH` / `UmbralMF_LOW`  out  LEN4 each  — registered Main thresholds.
- `UmbralVC_HIGH` / `UmbralVC_LOW`  out  LEN16 each  — registered VC thresholds; top level wires them to both V0 and V1.
- `UmbralD_HIGH` / `UmbralD_LOW`  out  LEN4 each  — registered D thresholds; top level wires them to both D0 and D1.
- `state`  out  3  — current state.
- `flow_en`  out  1  — permits writes into Main; top level ANDs it with `Main_wr`.
- `idle_out`  out  1  — 1 when `state` is IDLE.
- `active_out`  out  1  — 1 when `state` is ACTIVE.
- `error_out`  out  1  — 1 when `state` is ERROR.
- `cfg_bad`  out  1  — 1 in INIT while any loaded pair has LOW >= HIGH.
- `error_src`  out  5  — `fifo_error` value captured on entry to ERROR.

## Operation
- State encoding: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4.
- Outputs are Moore-decoded from the state register and the threshold registers; there are no combinational input-to-output paths.
- **Reset** (`reset_L`=0 at an edge): state=RESET, all threshold registers=0, idle counter=0, `error_src`=0. All outputs are therefore 0. Reset applied mid-operation, from any state, gives the same result.
- **RESET → INIT**: on the first edge with `reset_L`=1.
- **INIT**:
  - While `init`=1, every threshold register loads its `_in` value on every edge.
  - `cfg_bad` is the registered result of (any LOW >= HIGH) over the three pairs.
  - When `init`=0 and `cfg_bad`=0: go to IDLE.
  - When `init`=0 and `cfg_bad`=1: stay in INIT, waiting for a new load.
  - `fifo_error` is ignored in INIT.
- **IDLE**, priority order:
  1. `fifo_error`≠0 → ERROR.
  2. `init`=1 → INIT.
  3. `fifo_empty`≠5'b11111 → ACTIVE.
  4. Otherwise stay in IDLE.
- **ACTIVE**:
  - `fifo_error`≠0 → ERROR. This has the highest priority.
  - `init` is ignored; the FIFOs must drain to IDLE before a reload.
  - Idle counter: increments on each cycle with `fifo_empty`=5'b11111 and clears to 0 on any non-empty cycle.
  - When the counter reaches IDLE_CNT: go to IDLE and clear the counter.
  - The counter saturates and never wraps.
- **ERROR**:
  - On entry, `error_src` captures `fifo_error`.
  - The state is sticky until reset; `init` and later errors are ignored and `error_src` is not updated.
- `flow_en` is 1 only in IDLE and ACTIVE.
- Threshold registers hold their values in every state except INIT with `init`=1, and except reset.

## Timing
- Inputs are sampled at edge n. The new state and all decoded outputs are visible after edge n. Every decision therefore has exactly 1 cycle of latency.
- Threshold outputs update on the edge after the `_in` value is presented with `init`=1.
- `cfg_bad` lags the threshold load by 1 cycle. INIT→IDLE is evaluated against the registered `cfg_bad`, so leaving INIT takes at least 2 cycles after the last `init`=1 edge.
- ACTIVE→IDLE: `idle_out` rises on the edge that samples the IDLE_CNT-th consecutive all-empty cycle.
- Error and empty→non-empty in the same cycle: ERROR wins.
- `flow_en` drops on the same edge that enters ERROR. Words already in flight inside the FIFOs are not recalled.
- The idle counter width is $clog2(IDLE_CNT+1).

## Structure
- Shared package `interconnect_pkg` holds:
  - the state localparams (RESET…ERROR, 3 bits);
  - the `fifo_empty`/`fifo_error` bit indices (MAIN=0, VC0=1, VC1=2, D0=3, D1=4).
- Single module with no sub-modules. The idle counter is inline; it is too small to justify `idle_timer`.

## Test plan
- Reset held 3 cycles, then released → after edge 1 state=RESET with all outputs 0; after edge 2 state=INIT and `flow_en`=0.
- In INIT, `init`=1 with MF 12/3, VC 40/5, D 10/2, then `init`=0 → threshold outputs match the inputs; `cfg_bad`=0; state=IDLE 2 cycles later; `flow_en`=1.
- In INIT, `init`=1 with MF_LOW=9, MF_HIGH=4, then `init`=0 → `cfg_bad`=1 and the state stays INIT. Reload with 12/3 → IDLE.
- In IDLE, `fifo_empty`=5'b11110 for 1 cycle, then 5'b11111 → ACTIVE next cycle; with IDLE_CNT=4, IDLE exactly 4 all-empty cycles later. Inserting one non-empty cycle after 3 empty cycles restarts the count.
- In ACTIVE, `fifo_error`=5'b01000 together with `init`=1 → ERROR, `error_src`=5'b01000, `flow_en`=0. A later `fifo_error`=5'b00001 leaves `error_src` unchanged.
- Reset pulse while in ERROR → RESET with `error_src`=0 and thresholds=0, then INIT.
